ex_mult_stage: RTL and testbench
================================

Name: ex_mult_stage

Overview:
- Execute-stage operand/multiply block; consumes the forwarding selects from the forwarding unit.
- Each cycle, selects the EX operands from one of three sources: register-file data, EX/MEM result, or MEM/WB result.
- Feeds the selected operands to the ALU.
- For MUL instructions, latches the operands and runs a multi-cycle multiply.
- Holds the pipeline stalled until the product is valid.

Parameters:
- DATA_W, 64: datapath width.
- MULT_LAT, 3: total multiply occupancy in cycles. Legal range 2..8; assert at elaboration.
- CNT_W, 3: width of the latency counter. Must satisfy 2^CNT_W >= MULT_LAT.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- valid_in  in  1  ID/EX holds a valid instruction.
- is_mult  in  1  ID/EX instruction is MUL.
- flush  in  1  squash the current EX instruction (branch mispredict).
- forward_mux_1  in  2  operand A select: 00 = register file, 10 = EX/MEM, 01 = MEM/WB, 11 = register file.
- forward_mux_2  in  2  operand B select; same encoding as forward_mux_1.
- rs1_data  in  DATA_W  register-file value for RS1.
- rs2_data  in  DATA_W  register-file value for RS2.
- ex_mem_result  in  DATA_W  forwarded value from EX/MEM.
- mem_wb_result  in  DATA_W  forwarded value from MEM/WB.
- op_a  out  DATA_W  selected operand A (combinational, to ALU).
- op_b  out  DATA_W  selected operand B (combinational, to ALU).
- mult_result  out  DATA_W  registered product.
- mult_done  out  1  one-cycle pulse; mult_result is valid this cycle.
- stall_pipe  out  1  hold PC, IF/ID and ID/EX; insert bubble into EX/MEM.

Behaviour:
- Operand mux: purely combinational. op_a and op_b follow the select encoding every cycle, independent of FSM state.
- FSM has two states, IDLE and BUSY, plus a counter cnt (CNT_W bits).
- Start condition: start = IDLE & valid_in & is_mult & ~flush.
- IDLE with start:
  - Capture op_a and op_b into opa_q and opb_q (forwarded sources change while stalled).
  - cnt <= 1; go to BUSY.
  - stall_pipe = 1 in this cycle (combinational from start).
- BUSY with cnt < MULT_LAT-1: cnt <= cnt+1; stall_pipe = 1.
- BUSY with cnt == MULT_LAT-1:
  - mult_result <= low DATA_W bits of opa_q * opb_q, registered so it is visible this cycle.
  - mult_done = 1 and stall_pipe = 0 this cycle; ID/EX advances.
  - Return to IDLE.
- Latency: an instruction accepted at cycle T gets mult_done at cycle T+MULT_LAT-1. Total stall cycles = MULT_LAT-1.
- Back-to-back MULs: the cycle after done, the FSM is IDLE and ID/EX holds the next instruction, so a new start is allowed immediately. No idle gap is required.
- flush in BUSY: return to IDLE next edge. No mult_done is issued, stall_pipe drops in the same cycle (combinational), and mult_result holds its old value.
- flush in IDLE: suppresses start.
- Non-MUL instruction, or valid_in = 0: no state change; stall_pipe = 0; mult_done = 0.
- Reset:
  - State IDLE; cnt, opa_q, opb_q and mult_result all 0.
  - mult_done and stall_pipe are 0 while rst is high.
  - Reset mid-operation aborts the multiply with no done pulse.
- Overflow: the product is truncated to DATA_W bits with no flag (RV MUL semantics).

Optional Feature:
- Macro: MULT_HIGH_EN.
- Defined:
  - Adds input mul_high (1 bit), sampled at start and held in a register.
  - When the held value is 1, mult_result = upper DATA_W bits of the signed x signed 2*DATA_W-bit product (MULH).
- Undefined: the port is absent and only the low half is produced.

Decomposition:
- Shared package pipe_pkg holds:
  - fwd_sel encoding constants: FWD_RF = 2'b00, FWD_MEM_WB = 2'b01, FWD_EX_MEM = 2'b10.
  - FSM state encoding: IDLE = 0, BUSY = 1.
  - Defaults for DATA_W and MULT_LAT.
- One sub-module, fwd_operand_mux: a 3-input select that is instantiated twice, once for A and once for B.
- The FSM and multiplier stay in the top module.

Test Plan:
- forward_mux_1 = 10, forward_mux_2 = 01, ex_mem_result = 5, mem_wb_result = 9 -> op_a = 5, op_b = 9 in the same cycle. With select 11 -> op_a = rs1_data.
- MUL with op_a = 7, op_b = 6 accepted at T; change the forwarded inputs during T+1 -> stall_pipe is 1 at T and T+1; at T+2 mult_done = 1, mult_result = 42, stall_pipe = 0.
- Two consecutive MULs (3 x 4, then 0xFFFF_FFFF_FFFF_FFFF x 2) -> done pulses at T+2 and T+5. Second result = 0xFFFF_FFFF_FFFF_FFFE (truncation).
- flush asserted at T+1 during a MUL -> stall_pipe = 0 at T+1, no mult_done, FSM IDLE at T+2, mult_result unchanged.
- rst asserted at T+1 mid-multiply -> at T+2 all outputs and the result are 0. A new MUL at T+3 completes normally at T+5.
- With MULT_HIGH_EN defined: -1 x 2 with mul_high = 1 -> mult_result = 0xFFFF_FFFF_FFFF_FFFF.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: forwarding-select codes, EX multiply FSM states
// and default datapath/latency parameters.
package pipe_pkg;

   localparam logic [1:0] FWD_RF     = 2'b00;
   localparam logic [1:0] FWD_MEM_WB = 2'b01;
   localparam logic [1:0] FWD_EX_MEM = 2'b10;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mult_state_t;

   localparam int DATA_W_DEF   = 64;
   localparam int MULT_LAT_DEF = 3;
   localparam int CNT_W_DEF    = 3;

endpackage

// File: rtl/ex_mult_stage_if.sv
// EX-stage operand/multiply bus between the pipeline (master) and ex_mult_stage (slave).
// mul_high exists only when MULT_HIGH_EN is defined.
interface ex_mult_stage_if #(
   parameter int DATA_W = pipe_pkg::DATA_W_DEF
);
   logic              valid_in;
   logic              is_mult;
   logic              flush;
`ifdef MULT_HIGH_EN
   logic              mul_high;
`endif
   logic [1:0]        forward_mux_1;
   logic [1:0]        forward_mux_2;
   logic [DATA_W-1:0] rs1_data;
   logic [DATA_W-1:0] rs2_data;
   logic [DATA_W-1:0] ex_mem_result;
   logic [DATA_W-1:0] mem_wb_result;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic [DATA_W-1:0] mult_result;
   logic              mult_done;
   logic              stall_pipe;

   modport master (
      output valid_in, is_mult, flush,
`ifdef MULT_HIGH_EN
      output mul_high,
`endif
      output forward_mux_1, forward_mux_2, rs1_data, rs2_data,
      output ex_mem_result, mem_wb_result,
      input  op_a, op_b, mult_result, mult_done, stall_pipe
   );

   modport slave (
      input  valid_in, is_mult, flush,
`ifdef MULT_HIGH_EN
      input  mul_high,
`endif
      input  forward_mux_1, forward_mux_2, rs1_data, rs2_data,
      input  ex_mem_result, mem_wb_result,
      output op_a, op_b, mult_result, mult_done, stall_pipe
   );
endinterface

// File: rtl/fwd_operand_mux.sv
// Three-source EX operand select: register file, EX/MEM or MEM/WB result.
// The unused code 2'b11 falls back to the register file.
module fwd_operand_mux
   import pipe_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic [1:0]        sel,
   input  logic [DATA_W-1:0] rf_data,
   input  logic [DATA_W-1:0] ex_mem_data,
   input  logic [DATA_W-1:0] mem_wb_data,
   output logic [DATA_W-1:0] operand
);
   always_comb begin
      case (sel)
         FWD_EX_MEM: operand = ex_mem_data;
         FWD_MEM_WB: operand = mem_wb_data;
         default:    operand = rf_data;
      endcase
   end
endmodule

// File: rtl/ex_mult_stage.sv
// EX operand forwarding plus a multi-cycle MUL that stalls the pipe until done.
// Define MULT_HIGH_EN to add mul_high, selecting the signed upper half (MULH).
module ex_mult_stage
   import pipe_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int MULT_LAT = MULT_LAT_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic            clk,
   input  logic            rst,
   ex_mult_stage_if.slave  bus
);
   if (MULT_LAT < 2 || MULT_LAT > 8) begin : g_bad_lat
      $error("ex_mult_stage: MULT_LAT must be within 2..8");
   end
   if ((2 ** CNT_W) < MULT_LAT) begin : g_bad_cnt
      $error("ex_mult_stage: CNT_W too narrow for MULT_LAT");
   end

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULT_LAT - 1);

   logic [DATA_W-1:0] op_a, op_b;
   logic [DATA_W-1:0] opa_q, opb_q, res_q, product;
   mult_state_t       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              start, done, stall;

   fwd_operand_mux #(.DATA_W(DATA_W)) u_mux_a (
      .sel(bus.forward_mux_1), .rf_data(bus.rs1_data),
      .ex_mem_data(bus.ex_mem_result), .mem_wb_data(bus.mem_wb_result),
      .operand(op_a)
   );
   fwd_operand_mux #(.DATA_W(DATA_W)) u_mux_b (
      .sel(bus.forward_mux_2), .rf_data(bus.rs2_data),
      .ex_mem_data(bus.ex_mem_result), .mem_wb_data(bus.mem_wb_result),
      .operand(op_b)
   );

`ifdef MULT_HIGH_EN
   logic                       high_q;
   logic signed [2*DATA_W-1:0] prod_wide;
   assign prod_wide = $signed(opa_q) * $signed(opb_q);
   assign product   = high_q ? prod_wide[2*DATA_W-1:DATA_W] : prod_wide[DATA_W-1:0];
`else
   assign product   = opa_q * opb_q;
`endif

   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch behind.
      state_d = state_q;
      cnt_d   = cnt_q;
      start   = 1'b0;
      done    = 1'b0;
      stall   = 1'b0;
      case (state_q)
         IDLE: begin
            start = bus.valid_in & bus.is_mult & ~bus.flush;
            if (start) begin
               state_d = BUSY;
               cnt_d   = CNT_W'(1);
               stall   = 1'b1;
            end
         end
         BUSY: begin
            if (bus.flush) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               done    = 1'b1;
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               stall = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (rst) begin
         done  = 1'b0;
         stall = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         res_q   <= '0;
`ifdef MULT_HIGH_EN
         high_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         // Forwarded sources move while stalled, so the operands are frozen at start.
         if (start) begin
            opa_q  <= op_a;
            opb_q  <= op_b;
`ifdef MULT_HIGH_EN
            high_q <= bus.mul_high;
`endif
         end
         if (done) res_q <= product;
      end
   end

   // The product is bypassed in the completion cycle; res_q holds it afterwards.
   assign bus.op_a        = op_a;
   assign bus.op_b        = op_b;
   assign bus.mult_result = done ? product : res_q;
   assign bus.mult_done   = done;
   assign bus.stall_pipe  = stall;
endmodule

// File: tb/tb_ex_mult_stage.sv
// Self-checking bench for ex_mult_stage: operand-mux table, directed MUL
// sequences (latency, back-to-back, flush, reset) and a randomized run against a cycle-count model.
module tb_ex_mult_stage;
   localparam int LAT = 3;
   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   ex_mult_stage_if #(.DATA_W(64)) bus ();

   ex_mult_stage #(.DATA_W(64), .MULT_LAT(LAT), .CNT_W(3)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  s1, s2;
      logic [63:0] rs1, rs2, exm, mwb;
      logic [63:0] exp_a, exp_b;
   } mux_vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic m, input logic f,
                        input logic [1:0] s1, input logic [1:0] s2,
                        input logic [63:0] r1, input logic [63:0] r2,
                        input logic [63:0] em, input logic [63:0] mw);
      bus.valid_in      = v;
      bus.is_mult       = m;
      bus.flush         = f;
      bus.forward_mux_1 = s1;
      bus.forward_mux_2 = s2;
      bus.rs1_data      = r1;
      bus.rs2_data      = r2;
      bus.ex_mem_result = em;
      bus.mem_wb_result = mw;
   endtask

   task automatic idle_inputs();
      drive(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 64'd0, 64'd0, 64'd0, 64'd0);
   endtask

   task automatic check_ctl(input string tag, input logic e_stall, input logic e_done);
      check({tag, ".stall"}, {63'd0, bus.stall_pipe}, {63'd0, e_stall});
      check({tag, ".done"}, {63'd0, bus.mult_done}, {63'd0, e_done});
   endtask

   // Select rule stated directly: 10 -> EX/MEM, 01 -> MEM/WB, anything else -> register file.
   function automatic logic [63:0] sel_val(input logic [1:0] s, input logic [63:0] rf,
                                           input logic [63:0] em, input logic [63:0] mw);
      if (s == 2'b10) return em;
      if (s == 2'b01) return mw;
      return rf;
   endfunction

   function automatic logic [63:0] rnd64();
      case ($urandom_range(0, 3))
         0: return 64'($urandom_range(0, 15));
         1: return ONES;
         default: return {$urandom(), $urandom()};
      endcase
   endfunction

   mux_vec_t vecs[6];

   initial begin
      logic        pending;
      int          done_at;
      logic [63:0] pend_prod, last_res, ea, eb, er;
      logic        v, m, f, e_stall, e_done;
      logic [1:0]  s1, s2;
      logic [63:0] r1, r2, em, mw;

`ifdef MULT_HIGH_EN
      bus.mul_high = 1'b0;
`endif
      // Reset: a MUL request while rst is high must not stall or complete.
      drive(1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 64'd3, 64'd3, 64'd0, 64'd0);
      repeat (2) tick();
      #3;
      check_ctl("rst_hold", 1'b0, 1'b0);
      tick();
      idle_inputs();
      #3;
      check("rst_result", bus.mult_result, 64'd0);
      tick();
      rst = 1'b0;
      #3;
      check_ctl("post_rst", 1'b0, 1'b0);

      // Operand mux table.
      vecs[0] = '{2'b10, 2'b01, 64'd1, 64'd2, 64'd5, 64'd9, 64'd5, 64'd9};
      vecs[1] = '{2'b11, 2'b11, 64'hAA, 64'hBB, 64'd5, 64'd9, 64'hAA, 64'hBB};
      vecs[2] = '{2'b00, 2'b00, 64'h1234, 64'h5678, 64'd5, 64'd9, 64'h1234, 64'h5678};
      vecs[3] = '{2'b01, 2'b10, 64'd1, 64'd2, ONES, 64'd7, 64'd7, ONES};
      vecs[4] = '{2'b10, 2'b11, 64'd1, 64'hC0DE, 64'hDEAD, 64'd7, 64'hDEAD, 64'hC0DE};
      vecs[5] = '{2'b01, 2'b00, 64'd3, 64'd4, 64'd5, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd4};
      foreach (vecs[i]) begin
         tick();
         drive(1'b0, 1'b0, 1'b0, vecs[i].s1, vecs[i].s2, vecs[i].rs1, vecs[i].rs2,
               vecs[i].exm, vecs[i].mwb);
         #3;
         check($sformatf("mux%0d.op_a", i), bus.op_a, vecs[i].exp_a);
         check($sformatf("mux%0d.op_b", i), bus.op_b, vecs[i].exp_b);
         check_ctl($sformatf("mux%0d", i), 1'b0, 1'b0);
      end

      // 7 x 6 via forwarding; forwarded inputs change while stalled.
      tick(); drive(1'b1, 1'b1, 1'b0, 2'b10, 2'b01, 64'd0, 64'd0, 64'd7, 64'd6); #3;
      check_ctl("mul42.T", 1'b1, 1'b0);
      tick(); drive(1'b1, 1'b1, 1'b0, 2'b10, 2'b01, 64'd0, 64'd0, 64'd100, 64'd200); #3;
      check_ctl("mul42.T1", 1'b1, 1'b0);
      tick(); #3;
      check_ctl("mul42.T2", 1'b0, 1'b1);
      check("mul42.T2.result", bus.mult_result, 64'd42);
      tick(); idle_inputs(); #3;
      check_ctl("mul42.T3", 1'b0, 1'b0);
      check("mul42.T3.result", bus.mult_result, 64'd42);

      // Back-to-back: 3 x 4 then all-ones x 2 (truncated).
      tick(); drive(1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 64'd3, 64'd4, 64'd0, 64'd0); #3;
      check_ctl("b2b.T", 1'b1, 1'b0);
      tick(); #3;
      tick(); #3;
      check_ctl("b2b.T2", 1'b0, 1'b1);
      check("b2b.T2.result", bus.mult_result, 64'd12);
      tick(); drive(1'b1, 1'b1, 1'b0, 2'b00, 2'b00, ONES, 64'd2, 64'd0, 64'd0); #3;
      check_ctl("b2b.T3", 1'b1, 1'b0);
      check("b2b.T3.result", bus.mult_result, 64'd12);
      tick(); #3;
      check_ctl("b2b.T4", 1'b1, 1'b0);
      tick(); #3;
      check_ctl("b2b.T5", 1'b0, 1'b1);
      check("b2b.T5.result", bus.mult_result, 64'hFFFF_FFFF_FFFF_FFFE);

      // Flush mid-multiply, then an immediate new MUL proves the FSM is idle.
      tick(); drive(1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 64'd5, 64'd5, 64'd0, 64'd0); #3;
      check_ctl("flush.T", 1'b1, 1'b0);
      tick(); bus.flush = 1'b1; #3;
      check_ctl("flush.T1", 1'b0, 1'b0);
      check("flush.T1.result", bus.mult_result, 64'hFFFF_FFFF_FFFF_FFFE);
      tick(); drive(1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 64'd2, 64'd2, 64'd0, 64'd0); #3;
      check_ctl("flush.T2", 1'b1, 1'b0);
      check("flush.T2.result", bus.mult_result, 64'hFFFF_FFFF_FFFF_FFFE);
      tick(); #3;
      check_ctl("flush.T3", 1'b1, 1'b0);
      tick(); #3;
      check_ctl("flush.T4", 1'b0, 1'b1);
      check("flush.T4.result", bus.mult_result, 64'd4);

      // Reset mid-multiply, then a fresh MUL.
      tick(); drive(1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 64'd9, 64'd9, 64'd0, 64'd0); #3;
      check_ctl("rstmid.T", 1'b1, 1'b0);
      tick(); rst = 1'b1; #3;
      check_ctl("rstmid.T1", 1'b0, 1'b0);
      tick(); rst = 1'b0; idle_inputs(); #3;
      check_ctl("rstmid.T2", 1'b0, 1'b0);
      check("rstmid.T2.result", bus.mult_result, 64'd0);
      check("rstmid.T2.op_a", bus.op_a, 64'd0);
      tick(); drive(1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 64'd2, 64'd3, 64'd0, 64'd0); #3;
      check_ctl("rstmid.T3", 1'b1, 1'b0);
      tick(); idle_inputs(); #3;
      check_ctl("rstmid.T4", 1'b1, 1'b0);
      tick(); #3;
      check_ctl("rstmid.T5", 1'b0, 1'b1);
      check("rstmid.T5.result", bus.mult_result, 64'd6);

`ifdef MULT_HIGH_EN
      // Signed -1 x 2 upper half is all ones.
      tick(); drive(1'b1, 1'b1, 1'b0, 2'b00, 2'b00, ONES, 64'd2, 64'd0, 64'd0);
      bus.mul_high = 1'b1; #3;
      tick(); idle_inputs(); bus.mul_high = 1'b0; #3;
      tick(); #3;
      check_ctl("mulh.T2", 1'b0, 1'b1);
      check("mulh.T2.result", bus.mult_result, ONES);
`endif

      // Randomized run against a transaction model keyed on cycle numbers.
      tick(); rst = 1'b1; idle_inputs();
      tick(); rst = 1'b0;
      pending   = 1'b0;
      done_at   = 0;
      pend_prod = 64'd0;
      last_res  = 64'd0;
      for (int c = 0; c < 1500; c++) begin
         tick();
         v  = ($urandom_range(0, 3) != 0);
         m  = ($urandom_range(0, 1) == 1);
         f  = ($urandom_range(0, 7) == 0);
         s1 = 2'($urandom_range(0, 3));
         s2 = 2'($urandom_range(0, 3));
         r1 = rnd64(); r2 = rnd64(); em = rnd64(); mw = rnd64();
         drive(v, m, f, s1, s2, r1, r2, em, mw);
         #3;
         ea = sel_val(s1, r1, em, mw);
         eb = sel_val(s2, r2, em, mw);
         e_stall = 1'b0;
         e_done  = 1'b0;
         if (!pending) begin
            if (v && m && !f) begin
               pending   = 1'b1;
               done_at   = c + LAT - 1;
               pend_prod = ea * eb;
               e_stall   = 1'b1;
            end
         end else if (f) begin
            pending = 1'b0;
         end else if (c == done_at) begin
            e_done   = 1'b1;
            last_res = pend_prod;
            pending  = 1'b0;
         end else begin
            e_stall = 1'b1;
         end
         er = last_res;
         check($sformatf("rnd%0d.op_a", c), bus.op_a, ea);
         check($sformatf("rnd%0d.op_b", c), bus.op_b, eb);
         check_ctl($sformatf("rnd%0d", c), e_stall, e_done);
         check($sformatf("rnd%0d.result", c), bus.mult_result, er);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
